// File: rtl/ising_sweep_ctrl_if.sv
// Controller <-> matrix-datapath handshake bundle for the Ising sweep controller.
interface ising_sweep_ctrl_if #(
   parameter int unsigned N        = 4,
   parameter int unsigned DATABITS = 16
);
   logic                       mac_start;
   logic [7:0]                 mac_row;
   logic [N-1:0]               mac_spins;
   logic                       mac_done;
   logic signed [DATABITS-1:0] mac_field;
   logic signed [DATABITS-1:0] rand_thresh;

   // Controller side: launches requests, consumes field and threshold.
   modport master (
      output mac_start,
      output mac_row,
      output mac_spins,
      input  mac_done,
      input  mac_field,
      input  rand_thresh
   );

   // Datapath/RNG side.
   modport slave (
      input  mac_start,
      input  mac_row,
      input  mac_spins,
      output mac_done,
      output mac_field,
      output rand_thresh
   );
endinterface

// File: rtl/ising_sweep_ctrl.sv
// Ising sweep controller: walks every spin num_sweeps times, asks the matrix
// datapath for that spin's local field and sets the spin to (field > thresh).
// Optional feature macro FLIP_COUNT_EN adds a saturating 16-bit flip counter
// output (flip_count); without it the port and its logic do not exist.
module ising_sweep_ctrl #(
   parameter int unsigned N         = 4,
   parameter int unsigned DATABITS  = 16,
   parameter int unsigned SWEEPBITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SWEEPBITS-1:0] num_sweeps,
   input  logic [N-1:0]         spin_init,
   ising_sweep_ctrl_if.master   mac,
   output logic                 busy,
   output logic                 done,
   output logic [N-1:0]         spins
`ifdef FLIP_COUNT_EN
   ,
   output logic [15:0]          flip_count
`endif
);
   localparam int unsigned ROWBITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t                     state, state_n;
   logic [ROWBITS-1:0]         row, row_n;
   logic [SWEEPBITS-1:0]       sweep, sweep_n;
   logic [SWEEPBITS-1:0]       nsw, nsw_n;
   logic [N-1:0]               spins_n;
   logic                       mac_start_q;
   logic signed [DATABITS-1:0] field;
   logic signed [DATABITS-1:0] thresh;
   logic                       upd_bit;
   logic                       last_row;
   logic                       last_sweep;

   assign field      = mac.mac_field;
   assign thresh     = mac.rand_thresh;
   // Both operands signed, so this is a signed compare; a tie yields spin 0.
   assign upd_bit    = (field > thresh);
   assign last_row   = (row == ROWBITS'(N - 1));
   assign last_sweep = (sweep == (nsw - SWEEPBITS'(1)));

   assign mac.mac_start = mac_start_q;
   assign mac.mac_row   = row;
   assign mac.mac_spins = spins;

   // Next-state, run bookkeeping and spin update.
   always_comb begin
      state_n = state;
      row_n   = row;
      sweep_n = sweep;
      nsw_n   = nsw;
      spins_n = spins;
      unique case (state)
         IDLE: begin
            if (start) begin
               spins_n = spin_init;
               nsw_n   = num_sweeps;
               row_n   = '0;
               sweep_n = '0;
               state_n = (num_sweeps == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            if (mac.mac_done) begin
               for (int unsigned i = 0; i < N; i++) begin
                  if (row == ROWBITS'(i)) begin
                     spins_n[i] = upd_bit;
                  end
               end
               if (!last_row) begin
                  row_n = row + ROWBITS'(1);
               end else begin
                  row_n   = '0;
                  sweep_n = sweep + SWEEPBITS'(1);
               end
               state_n = (last_row && last_sweep) ? FIN : ISSUE;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register; outputs registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= '0;
         sweep       <= '0;
         nsw         <= '0;
         spins       <= '0;
         mac_start_q <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         row         <= row_n;
         sweep       <= sweep_n;
         nsw         <= nsw_n;
         spins       <= spins_n;
         mac_start_q <= (state_n == ISSUE);
         done        <= (state_n == FIN);
         busy        <= (state_n != IDLE);
      end
   end

`ifdef FLIP_COUNT_EN
   localparam int unsigned FLIPBITS = 16;

   logic [FLIPBITS-1:0] flips;
   logic                flip_c;

   // Does the pending update change the addressed spin?
   always_comb begin
      flip_c = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (row == ROWBITS'(i)) begin
            flip_c = (spins[i] != upd_bit);
         end
      end
   end

   // Saturating flip counter, restarted by each accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         flips <= '0;
      end else if ((state == IDLE) && start) begin
         flips <= '0;
      end else if ((state == WAIT) && mac.mac_done && flip_c && (flips != '1)) begin
         flips <= flips + FLIPBITS'(1);
      end
   end

   assign flip_count = flips;
`endif

endmodule
